// File: rtl/core_pkg.sv
// Types and constants shared by the RV32I pipeline control blocks.
// The hazard controller's state encoding lives here.
package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator. It flags an ID instruction that needs the result of a load still in EX.
module hazard_detect
    import core_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_regs_write,
    output logic       load_use
);

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read & ex_regs_write & (ex_rd != REG_ZERO) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, data-memory wait FSM with timeout watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_regs_write,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              err_next;
    logic              load_use;
    logic              mem_stall;
    logic              pipe_rules;

    hazard_detect u_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_regs_write(ex_regs_write),
        .load_use     (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            mem_err  <= err_next;
        end
    end

    // The watchdog saturates at TIMEOUT_VAL: reaching it moves to ERR instead of counting on.
    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        err_next     = mem_err;
        mem_stall    = 1'b0;
        pipe_rules   = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    mem_stall  = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    pipe_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    pipe_rules = 1'b1;
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == TIMEOUT_VAL) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase

        if (!rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (pipe_rules && ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (pipe_rules && load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall)    stall_q <= stall_q + CNT_W'(1);
            if (if_id_flush) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4); expected output vectors go through a scoreboard queue.
module tb_hazard_ctrl;

    // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_err}
    localparam logic [6:0] O_NONE  = 7'h00;
    localparam logic [6:0] O_FLUSH = 7'h14;
    localparam logic [6:0] O_LU    = 7'h64;
    localparam logic [6:0] O_MEM   = 7'h6A;
    localparam logic [6:0] O_ERR   = 7'h6B;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic        ex_mem_read = 1'b0, ex_regs_write = 1'b0, ex_br_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    logic [6:0]  exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          passed = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_regs_write(ex_regs_write),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic compare_output();
        logic [6:0] got;
        logic [6:0] exp;
        string      tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_err};
        check_output(tag, {25'd0, got}, {25'd0, exp});
    endtask

    // One cycle: drive at negedge, push expectation, sample mid-cycle; counters reflect earlier cycles only.
    task automatic apply_stimulus(input string tag, input logic r,
                                  input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2,
                                  input logic [4:0] rd, input logic mr, input logic rw,
                                  input logic br, input logic req, input logic rdy,
                                  input logic [6:0] exp);
        @(negedge clk);
        rst = r; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_regs_write = rw; ex_br_taken = br;
        mem_req = req; mem_ready = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        compare_output();
`ifdef HAZARD_PERF_CNT_EN
        check_output({tag, "_scnt"}, stall_cnt, exp_stall);
        check_output({tag, "_fcnt"}, flush_cnt, exp_flush);
`else
        check_output({tag, "_scnt"}, stall_cnt, 32'd0);
        check_output({tag, "_fcnt"}, flush_cnt, 32'd0);
`endif
        if (!r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (exp[6]) exp_stall++;
            if (exp[4]) exp_flush++;
        end
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        apply_stimulus(tag, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic mem_cycle(input string tag, input logic rdy, input logic [6:0] exp);
        apply_stimulus(tag, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, rdy, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        apply_stimulus("reset", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_FLUSH);
        idle("idle", O_NONE);

        // Load-use and its non-hazard variants
        apply_stimulus("lu_rs2",   1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        apply_stimulus("lu_gone",  1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        apply_stimulus("lu_x0",    1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        apply_stimulus("lu_unused",1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
        apply_stimulus("lu_rs1",   1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
        apply_stimulus("lu_nowr",  1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
        apply_stimulus("br_vs_lu", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_FLUSH);
        apply_stimulus("alu_dep",  1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);

        // Memory wait of three stalled cycles, memory stall must beat a branch
        mem_cycle("mw_run", 1'b0, O_MEM);
        apply_stimulus("mw_br", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_MEM);
        mem_cycle("mw_2",   1'b0, O_MEM);
        mem_cycle("mw_rdy", 1'b1, O_NONE);
        mem_cycle("mw_hit", 1'b1, O_NONE);
        idle("mw_after", O_NONE);

        // Load-use still applies in the cycle memory completes
        mem_cycle("mw2_run", 1'b0, O_MEM);
        apply_stimulus("mw2_lu", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_LU);
        idle("mw2_after", O_NONE);

        // Timeout into ERR, which ignores mem_ready until reset
        mem_cycle("to_run", 1'b0, O_MEM);
        for (int i = 1; i <= 4; i++) mem_cycle($sformatf("to_w%0d", i), 1'b0, O_MEM);
        mem_cycle("err_0",   1'b0, O_ERR);
        mem_cycle("err_rdy", 1'b1, O_ERR);
        idle("err_idle", O_ERR);
        apply_stimulus("err_rst", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FLUSH | 7'h01);
        idle("err_clr", O_NONE);

        // Ready arriving in the timeout cycle wins
        mem_cycle("tr_run", 1'b0, O_MEM);
        for (int i = 1; i <= 3; i++) mem_cycle($sformatf("tr_w%0d", i), 1'b0, O_MEM);
        mem_cycle("tr_rdy", 1'b1, O_NONE);
        idle("tr_after", O_NONE);

        // Reset asserted mid-wait
        mem_cycle("rw_run", 1'b0, O_MEM);
        mem_cycle("rw_w1",  1'b0, O_MEM);
        apply_stimulus("rw_rst", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_FLUSH);
        idle("rw_idle", O_NONE);
        idle("rw_idle2", O_NONE);

        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
